// File: rtl/ram_master.sv
// ram_master: single-port synchronous RAM burst controller.
//   Accepts write/read burst commands (start address, length-1) and
//   sequences them onto a RAM port with one access per cycle.
// Ports:
//   clk, reset_n               clock, async active-low reset
//   cmd_valid/ready/wr/addr/len command channel (len = beats-1)
//   wr_valid/ready/data        write-data beats (consumed only in WR)
//   rd_valid/data/last         read-data return, no backpressure
//   busy                       command or read return in flight
//   cen/wen/m_addr/m_din       RAM request (zeroed when cen=0)
//   m_dout                     RAM read data, valid cycle after issue
module ram_master (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [7:0]  cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [63:0] wr_data,
  output logic        rd_valid,
  output logic [63:0] rd_data,
  output logic        rd_last,
  output logic        busy,
  output logic        cen,
  output logic        wen,
  output logic [7:0]  m_addr,
  output logic [63:0] m_din,
  input  logic [63:0] m_dout
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_FLUSH} state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;   // read issued last edge, data on m_dout now
  logic        last_q, last_d;   // that read was the final beat of its burst

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    last_d  = 1'b0;
    cen     = 1'b0;
    wen     = 1'b0;
    m_addr  = 8'h00;
    m_din   = 64'h0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_wr ? S_WR : S_RD;
        end
      end
      S_WR: begin
        // No write data this cycle is a bubble: nothing issued, nothing advances.
        if (wr_valid) begin
          cen    = 1'b1;
          wen    = 1'b1;
          m_addr = addr_q;
          m_din  = wr_data;
          addr_d = addr_q + 8'd1;
          cnt_d  = cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_d = S_IDLE;
        end
      end
      S_RD: begin
        cen    = 1'b1;
        m_addr = addr_q;
        addr_d = addr_q + 8'd1;
        cnt_d  = cnt_q - 4'd1;
        pend_d = 1'b1;
        last_d = (cnt_q == 4'd0);
        if (cnt_q == 4'd0) state_d = S_FLUSH;
      end
      // One dead cycle lets the final read return drain before IDLE.
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= 8'h00;
      cnt_q   <= 4'h0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign wr_ready  = (state_q == S_WR);
  assign rd_valid  = pend_q;
  assign rd_last   = pend_q & last_q;
  assign rd_data   = pend_q ? m_dout : 64'h0;
  assign busy      = (state_q != S_IDLE) | pend_q;

endmodule

// File: tb/tb_ram_master.sv
module tb_ram_master;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid = 1'b0, cmd_wr = 1'b0;
  logic [7:0]  cmd_addr = 8'h0;
  logic [3:0]  cmd_len = 4'h0;
  logic        wr_valid = 1'b0;
  logic [63:0] wr_data = 64'h0;
  logic        cmd_ready, wr_ready, rd_valid, rd_last, busy, cen, wen;
  logic [63:0] rd_data, m_din, m_dout;
  logic [7:0]  m_addr;

  ram_master dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .busy(busy),
    .cen(cen), .wen(wen), .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout)
  );

  always #5 clk = ~clk;

  // RAM behavioural model attached to the DUT
  logic [63:0] mem [256];
  always @(posedge clk) begin
    if (cen && wen)  mem[m_addr] <= m_din;
    if (cen && !wen) m_dout <= mem[m_addr];
  end

  // Reference model: expected memory contents and expected traffic queues
  typedef struct packed { logic [63:0] d; logic l; } rd_exp_t;
  logic [63:0] ref_mem [256];
  rd_exp_t     exp_rd[$];
  logic [7:0]  exp_ra[$];
  logic [7:0]  exp_wa[$];
  logic [63:0] exp_wd[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s t=%0t", nm, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents traffic
  logic issue_prev = 1'b0;
  always @(negedge clk) begin
    chk("rd_timing", rd_valid, issue_prev & reset_n);
    issue_prev = cen & ~wen & reset_n;
    chk("busy", busy, !cmd_ready || rd_valid);
    if (cen && wen) begin
      if (exp_wa.size() == 0) fail_now("unexpected_write");
      else begin
        chk("wr_addr", m_addr, exp_wa.pop_front());
        chk("wr_data", m_din, exp_wd.pop_front());
      end
    end else if (cen) begin
      if (exp_ra.size() == 0) fail_now("unexpected_read_issue");
      else chk("rd_addr", m_addr, exp_ra.pop_front());
    end else begin
      chk("idle_bus", {wen, m_addr, m_din[54:0]}, 64'h0);
      chk("idle_din_hi", m_din[63:55], 64'h0);
    end
    if (rd_valid) begin
      if (exp_rd.size() == 0) fail_now("unexpected_rd_valid");
      else begin
        rd_exp_t e;
        e = exp_rd.pop_front();
        chk("rd_data", rd_data, e.d);
        chk("rd_last", rd_last, e.l);
      end
    end else begin
      chk("rd_data_idle", rd_data, 64'h0);
      chk("rd_last_idle", rd_last, 1'b0);
    end
  end

  // Present a command; exp_wait = cycles cmd_ready must stay low (-1 = any)
  task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [3:0] len,
                          input int exp_wait);
    int waits = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = len;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      waits++;
      if (waits > 200) begin fail_now("cmd_timeout"); break; end
    end
    if (exp_wait >= 0) chk("cmd_wait", waits, exp_wait);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_addr = 8'($urandom);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [3:0] len, input logic [15:0] bub,
                          input logic [63:0] base, input int exp_wait);
    int b = 0, cyc = 0;
    logic [7:0] wa;
    send_cmd(1'b1, a, len, exp_wait);
    while (b <= int'(len)) begin
      if (cyc < 16 && bub[cyc]) begin
        wr_valid = 1'b0;
        wr_data = {$urandom, $urandom};
      end else begin
        wa = a + 8'(b);
        wr_valid = 1'b1;
        wr_data = base + 64'(b);
        ref_mem[wa] = wr_data;
        exp_wa.push_back(wa);
        exp_wd.push_back(wr_data);
        b++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [3:0] len, input int exp_wait);
    logic [7:0] ra;
    rd_exp_t e;
    send_cmd(1'b0, a, len, exp_wait);
    for (int i = 0; i <= int'(len); i++) begin
      ra = a + 8'(i);
      exp_ra.push_back(ra);
      e.d = ref_mem[ra];
      e.l = (i == int'(len));
      exp_rd.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > 300) begin fail_now("idle_timeout"); break; end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int pw;
    logic wr;
    logic [7:0] a;
    logic [3:0] len;
    for (int i = 0; i < 256; i++) begin mem[i] = 64'h0; ref_mem[i] = 64'h0; end
    #1 reset_n = 1'b0;
    #2;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_outs", {wr_ready, rd_valid, rd_last, busy, cen, wen}, 6'b0);
    chk("rst_bus", {m_addr, rd_data[55:0]}, 64'h0);
    chk("rst_din", m_din, 64'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    wait_idle();

    // Directed: single beat, bubble, hold-off, wrap, max burst
    do_write(8'h10, 4'd0, 16'h0000, 64'h1234, 0);
    do_read (8'h10, 4'd0, 0);
    do_write(8'h20, 4'd3, 16'h0002, {$urandom, $urandom}, 2);
    do_read (8'h20, 4'd3, 0);
    do_read (8'h30, 4'd1, 5);
    do_write(8'hFE, 4'd3, 16'h0000, {$urandom, $urandom}, 3);
    do_read (8'hFE, 4'd3, 0);
    do_read (8'h00, 4'd15, 5);
    do_read (8'h80, 4'd0, 17);
    wait_idle();

    // Reset one cycle after the first read issue of a len=7 burst
    exp_ra.push_back(8'h40);
    send_cmd(1'b0, 8'h40, 4'd7, 0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_cen", cen, 1'b0);
    chk("midrst_rd_valid", rd_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_cmd_ready", cmd_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Randomized back-to-back traffic
    pw = 0;
    for (int t = 0; t < 40; t++) begin
      wr = 1'($urandom);
      a = 8'($urandom);
      len = 4'($urandom);
      if (wr) begin
        do_write(a, len, 16'($urandom & $urandom), {$urandom, $urandom}, pw);
        pw = 0;
      end else begin
        do_read(a, len, pw);
        pw = int'(len) + 2;
      end
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("ra_queue_empty", exp_ra.size(), 0);
    chk("wa_queue_empty", exp_wa.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 Parameters: none; address width is fixed at 8 bits and data width at 64 bits.
REQ-002 clk  input  1  single clock, all state updates on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge.
REQ-006 cmd_wr  input  1  1 = write burst, 0 = read burst.
REQ-007 cmd_addr  input  8  burst start address.
REQ-008 cmd_len  input  4  burst length minus one (1..16 beats).
REQ-009 wr_valid  input  1  write-data beat available.
REQ-010 wr_ready  output  1  write beat consumed when wr_valid && wr_ready at posedge.
REQ-011 wr_data  input  64  write-data beat.
REQ-012 rd_valid  output  1  read-data beat valid, single cycle, no backpressure.
REQ-013 rd_data  output  64  read-data beat.
REQ-014 rd_last  output  1  marks final read beat of a burst.
REQ-015 busy  output  1  command or read return in progress.
REQ-016 cen  output  1  RAM chip enable.
REQ-017 wen  output  1  RAM write enable.
REQ-018 m_addr  output  8  RAM address.
REQ-019 m_din  output  64  RAM write data.
REQ-020 m_dout  input  64  RAM read data, valid the cycle after a cen=1/wen=0 edge.

Function
REQ-021 States SHALL be IDLE, WR, RD and FLUSH.
REQ-022 cmd_ready SHALL be 1 only in IDLE; on acceptance, addr, remaining-beat count (cmd_len) and direction are latched; next state is WR (cmd_wr=1) or RD (cmd_wr=0).
REQ-023 WR: wr_ready SHALL be 1 combinationally; each cycle with wr_valid=1 drives cen=1, wen=1, m_addr=addr, m_din=wr_data, then addr and count advance.
REQ-024 WR with wr_valid=0: cen=0, wen=0, no advance (bubble); the burst resumes when data arrives.
REQ-025 WR: after the beat with count=0 is consumed, the next state SHALL be IDLE.
REQ-026 RD: each cycle drives cen=1, wen=0, m_addr=addr; addr advances; after issuing the count=0 beat, the next state SHALL be FLUSH.
REQ-027 FLUSH SHALL last exactly one cycle, issue nothing, and return to IDLE.
REQ-028 Read return: a registered pending flag set at each read-issue edge SHALL produce rd_valid=1 in the following cycle, with rd_data=m_dout passed through; latency is one cycle from the issue edge, throughput is one beat per cycle.
REQ-029 rd_last SHALL be 1 together with rd_valid for the beat issued with count=0 only.
REQ-030 Address arithmetic SHALL be modulo 256 (0xFF+1 -> 0x00); bursts wrap without error.
REQ-031 When cen=0: wen=0, m_addr=0, m_din=0; rd_data=0 when rd_valid=0.
REQ-032 busy SHALL be 1 when state!=IDLE or rd_valid=1.
REQ-033 cmd_valid outside IDLE SHALL be held off (not accepted, not lost); wr_valid outside WR SHALL be ignored.
REQ-034 A new command is accepted no earlier than the cycle after FLUSH (reads) or the last WR beat (writes).

Reset
REQ-035 reset_n=0 SHALL immediately force state=IDLE, clear addr, count and pending flag, and drive outputs: cmd_ready=1, wr_ready=0, rd_valid=0, rd_last=0, rd_data=0, busy=0, cen=0, wen=0, m_addr=0, m_din=0.
REQ-036 Reset mid-burst SHALL abort the burst; an outstanding read return SHALL NOT produce rd_valid after reset; operation resumes on the first posedge after reset_n rises.

Verification
REQ-037 Single write then read: write cmd addr=0x10 len=0 data=0x1234 -> one cen=1/wen=1 cycle at 0x10; read cmd addr=0x10 len=0 -> rd_valid=1, rd_last=1, rd_data=0x1234 one cycle after issue.
REQ-038 Write burst addr=0x20 len=3 with wr_valid low on the 2nd cycle -> exactly 4 write cycles at 0x20..0x23 with one bubble (cen=0); read back yields 4 consecutive rd_valid beats in order, rd_last on the 4th.
REQ-039 Wrap: write burst addr=0xFE len=3 -> writes at 0xFE, 0xFF, 0x00, 0x01; read back matches.
REQ-040 Hold-off: cmd_valid held high during a read burst -> cmd_ready=0 until IDLE; the second command is accepted in the cycle after FLUSH.
REQ-041 Reset mid-read: assert reset_n=0 the cycle after the first read issue of len=7 -> cen=0, rd_valid=0 immediately, busy=0, no further beats.
REQ-042 Max burst: read len=15 from addr=0x00 -> 16 back-to-back rd_valid beats, 16 issue cycles plus 1 FLUSH cycle, rd_last on the 16th only.
